// File: rtl/sync_sp_ram_be_nx32_ctrl_if.sv
// Request/response channel between an SoC-side initiator and the RAM controller.
// master = initiator side, slave = controller side.
interface sync_sp_ram_be_nx32_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  Req_SI;
    logic                  Gnt_SO;
    logic                  We_SI;
    logic [3:0]            BEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_SI;
    logic [31:0]           WData_SI;
    logic                  RValid_SO;
    logic                  RReady_SI;
    logic [31:0]           RData_DO;
    logic                  RWr_SO;
    logic                  RErr_SO;

    modport master (
        output Req_SI, We_SI, BEn_SI, Addr_SI, WData_SI, RReady_SI,
        input  Gnt_SO, RValid_SO, RData_DO, RWr_SO, RErr_SO
    );

    modport slave (
        input  Req_SI, We_SI, BEn_SI, Addr_SI, WData_SI, RReady_SI,
        output Gnt_SO, RValid_SO, RData_DO, RWr_SO, RErr_SO
    );
endinterface

// File: rtl/sync_sp_ram_be_nx32_ctrl.sv
// Controller for a synchronous single-port N x 32 byte-enable RAM: turns valid/ready
// requests into RAM accesses and returns in-order responses through a bounded FIFO.
module sync_sp_ram_be_nx32_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned OUT_REGS   = 0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    sync_sp_ram_be_nx32_ctrl_if.slave Bus,
    output logic                      CSel_SO,
    output logic                      WrEn_SO,
    output logic [3:0]                BEn_SO,
    output logic [ADDR_WIDTH-1:0]     Addr_DO,
    output logic [31:0]               WrData_DO,
    input  logic [31:0]               RdData_DI
);
    localparam int unsigned LAT = 1 + OUT_REGS;
    localparam int unsigned PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0]         MAX_OUTST = CW'(RESP_DEPTH);
    localparam logic [PW-1:0]         LAST_PTR  = PW'(RESP_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic            r_RstDone;
    logic [CW-1:0]   r_Outst;
    logic            r_TagV   [LAT];
    logic            r_TagWe  [LAT];
    logic            r_TagErr [LAT];
    logic [31:0]     r_FifoData [RESP_DEPTH];
    logic            r_FifoWr   [RESP_DEPTH];
    logic            r_FifoErr  [RESP_DEPTH];
    logic [PW-1:0]   r_WrPtr;
    logic [PW-1:0]   r_RdPtr;
    logic [CW-1:0]   r_Count;

    logic            w_Accept;
    logic            w_InRange;
    logic            w_Push;
    logic            w_Pop;
    logic            w_RValid;
    logic [31:0]     w_PushData;

    assign Bus.Gnt_SO = r_RstDone && (r_Outst < MAX_OUTST);
    assign w_Accept   = Bus.Req_SI && Bus.Gnt_SO;
    assign w_InRange  = {1'b0, Bus.Addr_SI} < DEPTH_LIM;

    assign CSel_SO   = w_Accept && w_InRange;
    assign WrEn_SO   = w_Accept && Bus.We_SI && w_InRange;
    assign BEn_SO    = Bus.BEn_SI;
    assign Addr_DO   = Bus.Addr_SI;
    assign WrData_DO = Bus.WData_SI;

    assign w_RValid   = (r_Count != '0);
    assign w_Pop      = w_RValid && Bus.RReady_SI;
    assign w_Push     = r_TagV[LAT-1];
    // Writes and errors never return RAM data; the read-during-write readout is dropped here.
    assign w_PushData = (r_TagWe[LAT-1] || r_TagErr[LAT-1]) ? '0 : RdData_DI;

    assign Bus.RValid_SO = w_RValid;
    assign Bus.RData_DO  = w_RValid ? r_FifoData[r_RdPtr] : '0;
    assign Bus.RWr_SO    = w_RValid && r_FifoWr[r_RdPtr];
    assign Bus.RErr_SO   = w_RValid && r_FifoErr[r_RdPtr];

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_RstDone <= 1'b0;
            r_Outst   <= '0;
        end else begin
            r_RstDone <= 1'b1;
            if (w_Accept && !w_Pop) begin
                r_Outst <= r_Outst + CW'(1);
            end else if (!w_Accept && w_Pop) begin
                r_Outst <= r_Outst - CW'(1);
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_TagV[i]   <= 1'b0;
                r_TagWe[i]  <= 1'b0;
                r_TagErr[i] <= 1'b0;
            end
        end else begin
            r_TagV[0]   <= w_Accept;
            r_TagWe[0]  <= Bus.We_SI;
            r_TagErr[0] <= !w_InRange;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_TagV[i]   <= r_TagV[i-1];
                r_TagWe[i]  <= r_TagWe[i-1];
                r_TagErr[i] <= r_TagErr[i-1];
            end
        end
    end

    // Pointers wrap explicitly so RESP_DEPTH need not be a power of two.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Count <= '0;
            for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
                r_FifoData[i] <= '0;
                r_FifoWr[i]   <= 1'b0;
                r_FifoErr[i]  <= 1'b0;
            end
        end else begin
            if (w_Push) begin
                r_FifoData[r_WrPtr] <= w_PushData;
                r_FifoWr[r_WrPtr]   <= r_TagWe[LAT-1];
                r_FifoErr[r_WrPtr]  <= r_TagErr[LAT-1];
                r_WrPtr             <= (r_WrPtr == LAST_PTR) ? '0 : r_WrPtr + PW'(1);
            end
            if (w_Pop) begin
                r_RdPtr <= (r_RdPtr == LAST_PTR) ? '0 : r_RdPtr + PW'(1);
            end
            if (w_Push && !w_Pop) begin
                r_Count <= r_Count + CW'(1);
            end else if (!w_Push && w_Pop) begin
                r_Count <= r_Count - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_depth_fits: assert property (@(posedge Clk_CI) 64'(DATA_DEPTH) <= (64'd1 << ADDR_WIDTH));
    a_resp_depth: assert property (@(posedge Clk_CI) RESP_DEPTH >= 1);
    a_no_ovf:     assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
                                   !(w_Push && (r_Count == MAX_OUTST)));
    a_no_udf:     assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
                                   !(w_Pop && (r_Count == '0)));
`endif
endmodule

// File: tb/tb_sync_sp_ram_be_nx32_ctrl.sv
// Bench for sync_sp_ram_be_nx32_ctrl: RAM model with output register, expected-response
// queue with acceptance timestamps, directed scenarios followed by random traffic.
module tb_sync_sp_ram_be_nx32_ctrl;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned OREGS = 1;
    localparam int unsigned RDEP  = 4;
    localparam int unsigned LAT   = 1 + OREGS;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        err;
        int unsigned acc;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          csel, wren;
    logic [3:0]    ben_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic [31:0]   rdata_i;

    logic [31:0]   ram [1024];
    logic [31:0]   ram_q0;
    logic [31:0]   ref_mem [1024];
    resp_t         q [$];
    int unsigned   cyc = 0;
    int unsigned   since_rst = 0;
    int unsigned   n_acc = 0;
    int unsigned   n_chk = 0;
    int unsigned   n_err = 0;
    logic [31:0]   last_rdata = '0;

    sync_sp_ram_be_nx32_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    sync_sp_ram_be_nx32_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_DEPTH(DEPTH),
        .OUT_REGS  (OREGS),
        .RESP_DEPTH(RDEP)
    ) dut (
        .Clk_CI   (clk),
        .Rst_RBI  (rst_n),
        .Bus      (bus),
        .CSel_SO  (csel),
        .WrEn_SO  (wren),
        .BEn_SO   (ben_o),
        .Addr_DO  (addr_o),
        .WrData_DO(wdata_o),
        .RdData_DI(rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM: registered read (old data on write), plus OUT_REGS output stage.
    always @(posedge clk) begin
        if (csel) begin
            if (wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (ben_o[b]) ram[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
                end
            end
            ram_q0 <= ram[addr_o];
        end
        rdata_i <= ram_q0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    // Reference model: grant = out of reset one cycle and fewer than RDEP unreturned requests;
    // a request accepted in cycle t must be at the queue head from cycle t+LAT+1 on.
    always @(negedge clk) begin
        logic  exp_gnt, acc, inr, exp_rv;
        resp_t r;
        exp_gnt = rst_n && (since_rst >= 1) && (q.size() < RDEP);
        chk("gnt", bus.Gnt_SO, exp_gnt);
        acc = bus.Req_SI && exp_gnt;
        inr = bus.Addr_SI < DEPTH;
        chk("csel", csel, acc && inr);
        chk("wren", wren, acc && bus.We_SI && inr);
        if (acc && inr) begin
            chk("ram_addr", addr_o, bus.Addr_SI);
            if (bus.We_SI) begin
                chk("ram_wdata", wdata_o, bus.WData_SI);
                chk("ram_ben", ben_o, bus.BEn_SI);
            end
        end
        exp_rv = (q.size() > 0) && (cyc >= q[0].acc + LAT + 1);
        chk("rvalid", bus.RValid_SO, exp_rv);
        if (!rst_n) begin
            chk("rst_rdata", bus.RData_DO, 0);
            chk("rst_rwr", bus.RWr_SO, 0);
            chk("rst_rerr", bus.RErr_SO, 0);
        end
        if (exp_rv) begin
            chk("rdata", bus.RData_DO, q[0].data);
            chk("rwr", bus.RWr_SO, q[0].wr);
            chk("rerr", bus.RErr_SO, q[0].err);
            if (bus.RReady_SI) begin
                if (!q[0].wr && !q[0].err) last_rdata = bus.RData_DO;
                void'(q.pop_front());
            end
        end
        if (acc) begin
            n_acc++;
            r.wr   = bus.We_SI;
            r.err  = !inr;
            r.acc  = cyc;
            r.data = (bus.We_SI || !inr) ? 32'h0 : ref_mem[bus.Addr_SI];
            q.push_back(r);
            if (bus.We_SI && inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.BEn_SI[b]) ref_mem[bus.Addr_SI][8*b +: 8] = bus.WData_SI[8*b +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                          input logic [31:0] d);
        bit done = 0;
        bus.Req_SI   = 1'b1;
        bus.We_SI    = we;
        bus.BEn_SI   = be;
        bus.Addr_SI  = a;
        bus.WData_SI = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.Gnt_SO;
            step();
        end
        bus.Req_SI = 1'b0;
        if (!done) chk("req_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        chk("drain", q.size(), 0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 7));
            1:       return AW'($urandom_range(990, 1023));
            default: return AW'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        int unsigned a0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 32'h100 + i;
            ref_mem[i] = 32'h100 + i;
        end
        bus.Req_SI    = 1'b1;
        bus.We_SI     = 1'b1;
        bus.BEn_SI    = 4'hF;
        bus.Addr_SI   = 10'd3;
        bus.WData_SI  = 32'h0BAD_0BAD;
        bus.RReady_SI = 1'b1;

        // Reset with request held high.
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk); chk("rel_gnt0", bus.Gnt_SO, 0);
        @(negedge clk); chk("rel_gnt1", bus.Gnt_SO, 1);
        step();
        bus.Req_SI = 1'b0;
        drain();

        // Byte merge.
        do_req(1'b1, 4'b1111, 10'd5, 32'hDEADBEEF);
        do_req(1'b1, 4'b0001, 10'd5, 32'h000000AA);
        do_req(1'b0, 4'b0000, 10'd5, 32'h0);
        drain();
        chk("merge", last_rdata, 32'hDEADBEAA);

        // Throughput: back-to-back reads, one response per cycle.
        a0 = n_acc;
        for (int i = 0; i < 8; i++) do_req(1'b0, 4'h0, AW'(i), 32'h0);
        chk("tput_acc", n_acc - a0, 8);
        drain();
        chk("tput_last", last_rdata, 32'h107);

        // Backpressure: only RDEP requests may be outstanding.
        bus.RReady_SI = 1'b0;
        a0 = n_acc;
        bus.Req_SI = 1'b1; bus.We_SI = 1'b0; bus.Addr_SI = 10'd20;
        repeat (10) step();
        bus.Req_SI = 1'b0;
        chk("bp_acc", n_acc - a0, RDEP);
        bus.RReady_SI = 1'b1;
        drain();
        @(negedge clk); chk("bp_gnt", bus.Gnt_SO, 1);
        step();

        // Out of range then a boundary in-range read.
        do_req(1'b0, 4'h0, 10'd1000, 32'h0);
        do_req(1'b1, 4'hF, 10'd1023, 32'h12345678);
        do_req(1'b0, 4'h0, 10'd999, 32'h0);
        drain();
        chk("oor_999", last_rdata, 32'h100 + 999);

        // Reset with responses queued.
        bus.RReady_SI = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1'b0, 4'h0, AW'(10 + i), 32'h0);
        repeat (5) step();
        q.delete();
        rst_n = 1'b0;
        #1 chk("midrst_rvalid", bus.RValid_SO, 0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.RReady_SI = 1'b1;
        @(negedge clk); chk("midrst_gnt0", bus.Gnt_SO, 0);
        @(negedge clk); chk("midrst_gnt1", bus.Gnt_SO, 1);
        repeat (6) step();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.Req_SI    = ($urandom_range(0, 3) != 0);
            bus.We_SI     = $urandom_range(0, 1);
            bus.BEn_SI    = 4'($urandom_range(0, 15));
            bus.Addr_SI   = pick_addr();
            bus.WData_SI  = $urandom;
            bus.RReady_SI = (i % 100 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
        end
        bus.Req_SI    = 1'b0;
        bus.RReady_SI = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
